// File: rtl/pe_seq_pkg.sv
// Package: pe_seq_pkg
// Shared state encoding, default widths and a counter-width helper for the
// pe_dot_sequencer slice.
package pe_seq_pkg;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_ACC_W       = 32;
  localparam int DEF_LEN_W       = 8;
  localparam int DEF_TIMEOUT_CYC = 15;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    DONE
  } seq_state_t;

  // Bits needed for a counter that must reach `limit` without wrapping.
  function automatic int cnt_w(input int limit);
    return $clog2(limit + 2);
  endfunction

endpackage

// File: rtl/pe_seq_watchdog.sv
// Module: pe_seq_watchdog
// Loadable cycle counter that flags when a PE has sat in WAIT for LIMIT+1
// cycles. Only built when PE_SEQ_TIMEOUT_EN is defined.
`ifdef PE_SEQ_TIMEOUT_EN
module pe_seq_watchdog
  import pe_seq_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = cnt_w(LIMIT);

  logic [CW-1:0] count;

  // Count enabled cycles since the last load; saturate once expired.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

  // count holds the cycles already spent, so equality here means the current
  // cycle is number LIMIT+1.
  assign expired = (count == CW'(LIMIT));

endmodule
`endif

// File: rtl/pe_dot_sequencer.sv
// Module: pe_dot_sequencer
// Drives a single systolic MAC PE through an N-term dot product. A job gives
// the term count; operand pairs are issued one at a time over the PE
// strobe/busy handshake and each PE result is fed back as the next acc_in.
// The final sum is returned on a valid/ready port.
// Optional feature: define PE_SEQ_TIMEOUT_EN to add a WAIT-state watchdog and
// the res_err output.
module pe_dot_sequencer
  import pe_seq_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  // job command
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  // operand stream
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_data,
  input  logic [DATA_W-1:0] op_weight,
  // result
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
`ifdef PE_SEQ_TIMEOUT_EN
  output logic              res_err,
`endif
  // PE interface
  output logic              pe_i_stb,
  input  logic              pe_o_busy,
  output logic [DATA_W-1:0] pe_data,
  output logic [DATA_W-1:0] pe_weight,
  output logic [ACC_W-1:0]  pe_acc,
  input  logic              pe_o_stb,
  input  logic [ACC_W-1:0]  pe_acc_out,
  output logic              pe_i_busy
);

  seq_state_t       state;
  logic [LEN_W-1:0] remaining;
  logic [ACC_W-1:0] acc;

`ifdef PE_SEQ_TIMEOUT_EN
  logic wd_expired;

  // Reloaded on every cycle outside WAIT, so each term gets a fresh budget.
  pe_seq_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .load    (state != WAIT),
    .en      (state == WAIT),
    .expired (wd_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYC);
`endif

  // Handshake flags decode straight from the state register.
  assign op_ready  = (state == FETCH);
  assign res_valid = (state == DONE);
  assign pe_i_busy = (state != WAIT);

  // The strobe depends on pe_o_busy combinationally so it is high for exactly
  // the one cycle the PE is able to take the operands.
  assign pe_i_stb  = (state == ISSUE) && !pe_o_busy;

  // The PE samples acc_in late; acc only moves on job start or pe_o_stb, so it
  // is stable from ISSUE through the returning strobe.
  assign pe_acc    = acc;
  assign res_data  = acc;

  // Sequencer FSM: state, term counter, running sum and operand latches.
  // NOTE: every register here is assigned with <= so all next-state values are
  // computed from the same pre-edge snapshot; = would leak updates mid-block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      acc       <= '0;
      pe_data   <= '0;
      pe_weight <= '0;
      // cmd_ready is a register so it reads 0 while reset is held and rises
      // on the first clock after release.
      cmd_ready <= 1'b0;
`ifdef PE_SEQ_TIMEOUT_EN
      res_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            remaining <= cmd_len;
            acc       <= '0;
            cmd_ready <= 1'b0;
            state     <= (cmd_len == '0) ? DONE : FETCH;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        FETCH: begin
          if (op_valid) begin
            pe_data   <= op_data;
            pe_weight <= op_weight;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          if (!pe_o_busy) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (pe_o_stb) begin
            acc       <= pe_acc_out;
            remaining <= remaining - LEN_W'(1);
            state     <= (remaining == LEN_W'(1)) ? DONE : FETCH;
          end
`ifdef PE_SEQ_TIMEOUT_EN
          else if (wd_expired) begin
            // Abandon the remaining terms and report the partial sum.
            res_err <= 1'b1;
            state   <= DONE;
          end
`endif
        end

        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
`ifdef PE_SEQ_TIMEOUT_EN
            res_err   <= 1'b0;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_dot_sequencer.sv
// Testbench: tb_pe_dot_sequencer
// Randomized jobs against a behavioural PE and an arithmetic dot-product model.
// Define PE_SEQ_TIMEOUT_EN to also exercise the watchdog.
module tb_pe_dot_sequencer;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [DATA_W-1:0] op_data = '0;
  logic [DATA_W-1:0] op_weight = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [ACC_W-1:0]  res_data;
  logic              res_err;
  logic              pe_i_stb;
  logic              pe_o_busy;
  logic [DATA_W-1:0] pe_data;
  logic [DATA_W-1:0] pe_weight;
  logic [ACC_W-1:0]  pe_acc;
  logic              pe_o_stb = 1'b0;
  logic [ACC_W-1:0]  pe_acc_out = '0;
  logic              pe_i_busy;

  pe_dot_sequencer #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_data    (op_data),
    .op_weight  (op_weight),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
`ifdef PE_SEQ_TIMEOUT_EN
    .res_err    (res_err),
`endif
    .pe_i_stb   (pe_i_stb),
    .pe_o_busy  (pe_o_busy),
    .pe_data    (pe_data),
    .pe_weight  (pe_weight),
    .pe_acc     (pe_acc),
    .pe_o_stb   (pe_o_stb),
    .pe_acc_out (pe_acc_out),
    .pe_i_busy  (pe_i_busy)
  );

`ifndef PE_SEQ_TIMEOUT_EN
  assign res_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic abort(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // ---------------- behavioural PE ----------------
  logic              stub_busy = 1'b0;
  logic              extra_busy = 1'b0;
  logic              stub_hang = 1'b0;
  logic              busy_noise = 1'b0;
  int                stub_cnt = 0;
  int                pe_lat = 4;
  logic [DATA_W-1:0] sd = '0;
  logic [DATA_W-1:0] sw = '0;
  logic [ACC_W-1:0]  acc_at_issue = '0;

  assign pe_o_busy = stub_busy | extra_busy;

  // MAC with a pe_lat cycle pipeline; acc_in is read when the result is made.
  always @(posedge clk) begin
    if (reset) begin
      stub_busy  <= 1'b0;
      extra_busy <= 1'b0;
      pe_o_stb   <= 1'b0;
      pe_acc_out <= '0;
      stub_cnt   <= 0;
    end else begin
      pe_o_stb   <= 1'b0;
      extra_busy <= busy_noise && !stub_busy && ($urandom_range(0, 3) == 0);
      if (!stub_busy) begin
        if (pe_i_stb && !pe_o_busy) begin
          sd           <= pe_data;
          sw           <= pe_weight;
          acc_at_issue <= pe_acc;
          stub_busy    <= 1'b1;
          stub_cnt     <= pe_lat;
        end
      end else if (stub_cnt > 1) begin
        stub_cnt <= stub_cnt - 1;
      end else if (!stub_hang && !pe_i_busy) begin
        pe_o_stb   <= 1'b1;
        pe_acc_out <= pe_acc + ACC_W'(sd) * ACC_W'(sw);
        stub_busy  <= 1'b0;
      end
    end
  end

  // ---------------- model ----------------
  int               opd[16];
  int               opw[16];
  logic [ACC_W-1:0] exp_res = '0;
  logic             exp_err = 1'b0;
  logic [ACC_W-1:0] last_res = '0;
  logic             in_job = 1'b0;
  int               op_hs = 0;
  logic             op_rdy_seen = 1'b0;
  int               res_wait = 0;

  function automatic logic [ACC_W-1:0] model_dot(input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) s += longint'(opd[i]) * longint'(opw[i]);
    return ACC_W'(s);
  endfunction

  // Compare process: outputs against the model on every meaningful cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (op_valid && op_ready) op_hs++;
      if (op_ready) op_rdy_seen = 1'b1;
      if (res_valid) begin
        check("res_data", res_data, exp_res);
        check("res_err", res_err, exp_err);
      end
      if (stub_busy) check("pe_acc_hold", pe_acc, acc_at_issue);
      if (in_job) check("cmd_ready_in_job", cmd_ready, 0);
    end
  end

  task automatic check_reset_state();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_op_ready", op_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_pe_i_stb", pe_i_stb, 0);
    check("rst_pe_i_busy", pe_i_busy, 1);
    check("rst_pe_acc", pe_acc, 0);
    check("rst_pe_data", pe_data, 0);
    check("rst_pe_weight", pe_weight, 0);
  endtask

  task automatic accept_cmd(input int len);
    int n = 0;
    cmd_len   = LEN_W'(len);
    cmd_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n > 50) abort("cmd_accept");
    end while (!cmd_ready);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    in_job = 1'b1;
  endtask

  task automatic feed_op(input int i, input int gap);
    int n = 0;
    op_data   = DATA_W'(opd[i]);
    op_weight = DATA_W'(opw[i]);
    op_valid  = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n > 200) abort("op_ready");
    end while (!op_ready);
    @(posedge clk);
    #1 op_valid = 1'b0;
    op_data   = DATA_W'($urandom);
    op_weight = DATA_W'($urandom);
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic take_result(input int rdy_delay);
    res_wait = 0;
    do begin
      @(negedge clk);
      res_wait++;
      if (res_wait > 300) abort("res_valid");
    end while (!res_valid);
    repeat (rdy_delay) @(negedge clk);
    last_res  = res_data;
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    in_job = 1'b0;
  endtask

  task automatic run_job(input int len, input int gap, input int rdy_delay);
    exp_res     = model_dot(len);
    exp_err     = 1'b0;
    op_hs       = 0;
    op_rdy_seen = 1'b0;
    accept_cmd(len);
    for (int i = 0; i < len; i++) feed_op(i, gap);
    take_result(rdy_delay);
    check("op_handshakes", op_hs, len);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state();
    in_job   = 1'b0;
    op_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    abort("global_time");
  end

  initial begin
    int n;
    int w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1 reset = 1'b0;

    // Three-term literal: 2*3 + 4*5 + 6*7 = 68.
    opd[0] = 2; opw[0] = 3;
    opd[1] = 4; opw[1] = 5;
    opd[2] = 6; opw[2] = 7;
    run_job(3, 0, 0);
    check("dot3_literal", last_res, 68);

    // Zero-length job: immediate zero result, no operand port activity.
    run_job(0, 0, 0);
    check("len0_literal", last_res, 0);
    check("len0_latency", res_wait, 1);
    check("len0_op_ready_seen", op_rdy_seen, 0);

    // Wrap at 16 bits: 2*65025 mod 65536 = 64514.
    opd[0] = 255; opw[0] = 255;
    opd[1] = 255; opw[1] = 255;
    run_job(2, 0, 0);
    check("wrap_literal", last_res, 64514);

    // Slow consumer and gappy producer with a busy PE.
    busy_noise = 1'b1;
    for (int i = 0; i < 3; i++) begin
      opd[i] = int'($urandom_range(0, 255));
      opw[i] = int'($urandom_range(0, 255));
    end
    run_job(3, 3, 5);

    // Randomized jobs.
    for (int j = 0; j < 25; j++) begin
      int len;
      len        = int'($urandom_range(1, 8));
      pe_lat     = int'($urandom_range(4, 7));
      busy_noise = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        opd[i] = int'($urandom_range(0, 255));
        opw[i] = int'($urandom_range(0, 255));
      end
      run_job(len, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
    end
    busy_noise = 1'b0;
    pe_lat     = 4;

    // Reset while waiting on the PE for term 2, then a fresh job.
    opd[0] = 9;  opw[0] = 9;
    opd[1] = 10; opw[1] = 11;
    opd[2] = 12; opw[2] = 13;
    exp_res = model_dot(3);
    exp_err = 1'b0;
    accept_cmd(3);
    feed_op(0, 0);
    feed_op(1, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 50) abort("wait_state_term2");
    end while (pe_i_busy);
    pulse_reset();
    opd[0] = 3; opw[0] = 3;
    run_job(1, 0, 0);
    check("after_reset_literal", last_res, 9);

`ifdef PE_SEQ_TIMEOUT_EN
    // PE never answers: watchdog ends the job after 16 WAIT cycles.
    stub_hang = 1'b1;
    opd[0] = 5; opw[0] = 5;
    exp_res = '0;
    exp_err = 1'b1;
    op_hs   = 0;
    accept_cmd(2);
    feed_op(0, 0);
    w = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!pe_i_busy) w++;
      if (n > 100) abort("watchdog");
    end while (!res_valid);
    check("wd_wait_cycles", w, 16);
    check("wd_res_err", res_err, 1);
    take_result(0);
    check("wd_op_handshakes", op_hs, 1);
    stub_hang = 1'b0;
    pulse_reset();
`else
    w = 0;
    n = w;
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
